// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side signals of uart_tx_arbiter, grouped as one bundle.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int W_OUT   = 16
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0][W_OUT-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          m_valid;
  logic [W_OUT-1:0]              m_data;
  logic                          m_ready;
  logic [ID_W-1:0]               grant_id;
  logic                          busy;

  // Arbiter side.
  modport master (
    input  req_valid, req_data, m_ready,
    output req_ready, m_valid, m_data, grant_id, busy
  );

  // Requesters and UART side.
  modport slave (
    output req_valid, req_data, m_ready,
    input  req_ready, m_valid, m_data, grant_id, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit path among NUM_REQ requesters.
// Optional macro UART_ARB_PRIO_EN gives requester 0 strict priority over the rotation.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int W_OUT         = 16,
  parameter int BITS_PER_WORD = 8,
  parameter int GAP_CLOCKS    = 32
) (
  input logic               clk,
  input logic               rstn,
  uart_tx_arbiter_if.master bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = (GAP_CLOCKS > 2) ? $clog2(GAP_CLOCKS) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CLOCKS > 0) ? GAP_CLOCKS - 1 : 0);
  localparam bit HAS_GAP = (GAP_CLOCKS > 0);

  if ((W_OUT % BITS_PER_WORD) != 0) begin : g_bad_w_out
    $fatal(1, "uart_tx_arbiter: W_OUT must be a multiple of BITS_PER_WORD");
  end
  if ((NUM_REQ < 2) || (NUM_REQ > 8)) begin : g_bad_num_req
    $fatal(1, "uart_tx_arbiter: NUM_REQ must be within 2..8");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic [ID_W-1:0]    rr_ptr_r;
  logic [ID_W-1:0]    rr_next_s;
  logic [ID_W-1:0]    win_s;
  logic [ID_W-1:0]    idx_s;
  logic               found_s;
  logic               take_s;
  logic               grant_s;
  logic               run_r;
  logic [NUM_REQ-1:0] req_ready_s;
  logic               m_valid_r;
  logic [W_OUT-1:0]   m_data_r;
  logic [ID_W-1:0]    grant_id_r;
  logic [GAP_W-1:0]   gap_cnt_r;

  // Winner search: first valid requester scanning upward from the rr pointer.
  always_comb begin
    win_s   = ID_W'(0);
    found_s = 1'b0;
    idx_s   = ID_W'(0);
    take_s  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_s   = ID_W'((int'(rr_ptr_r) + i) % NUM_REQ);
      take_s  = !found_s && bus.req_valid[idx_s];
      win_s   = take_s ? idx_s : win_s;
      found_s = found_s | take_s;
    end
`ifdef UART_ARB_PRIO_EN
    win_s = bus.req_valid[0] ? ID_W'(0) : win_s;
`endif
  end

  // run_r keeps req_ready low while reset is asserted and on the release edge.
  assign grant_s   = run_r && found_s && (state_r == ST_IDLE);
  assign rr_next_s = (win_s == ID_W'(NUM_REQ - 1)) ? ID_W'(0) : win_s + ID_W'(1);

  // Next-state and accept-strobe decode.
  always_comb begin
    next_state_s = state_r;
    req_ready_s  = '0;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          req_ready_s[win_s] = 1'b1;
          next_state_s       = ST_SEND;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (bus.m_ready) begin
          next_state_s = HAS_GAP ? ST_GAP : ST_IDLE;
        end else begin
          next_state_s = ST_SEND;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_W'(0)) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_GAP;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Control state: FSM, rotation pointer and idle-gap counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= ST_IDLE;
      run_r     <= 1'b0;
      rr_ptr_r  <= ID_W'(0);
      gap_cnt_r <= GAP_W'(0);
    end else begin
      state_r <= next_state_s;
      run_r   <= 1'b1;
`ifdef UART_ARB_PRIO_EN
      if (grant_s && (win_s != ID_W'(0))) begin
        rr_ptr_r <= rr_next_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
`else
      if (grant_s) begin
        rr_ptr_r <= rr_next_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
`endif
      if ((state_r == ST_SEND) && bus.m_ready) begin
        gap_cnt_r <= GAP_LOAD;
      end else if ((state_r == ST_GAP) && (gap_cnt_r != GAP_W'(0))) begin
        gap_cnt_r <= gap_cnt_r - GAP_W'(1);
      end else begin
        gap_cnt_r <= gap_cnt_r;
      end
    end
  end

  // Held packet and its owner, captured on the accept edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid_r  <= 1'b0;
      m_data_r   <= '0;
      grant_id_r <= ID_W'(0);
    end else begin
      m_valid_r <= (next_state_s == ST_SEND);
      if (grant_s) begin
        m_data_r   <= bus.req_data[win_s];
        grant_id_r <= win_s;
      end else begin
        m_data_r   <= m_data_r;
        grant_id_r <= grant_id_r;
      end
    end
  end

  // busy also covers the accept cycle so back-to-back traffic never shows a hole.
  assign bus.busy      = (state_r != ST_IDLE) || grant_s;
  assign bus.req_ready = req_ready_s;
  assign bus.m_valid   = m_valid_r;
  assign bus.m_data    = m_data_r;
  assign bus.grant_id  = grant_id_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters/gap 32 and 3 requesters/gap 0).
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rstn;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(4), .W_OUT(16)) bus4 ();
  uart_tx_arbiter_if #(.NUM_REQ(3), .W_OUT(16)) bus3 ();

  uart_tx_arbiter #(.NUM_REQ(4), .W_OUT(16), .BITS_PER_WORD(8), .GAP_CLOCKS(32)) dut (
    .clk(clk), .rstn(rstn), .bus(bus4)
  );
  uart_tx_arbiter #(.NUM_REQ(3), .W_OUT(16), .BITS_PER_WORD(8), .GAP_CLOCKS(0)) dut3 (
    .clk(clk), .rstn(rstn), .bus(bus3)
  );

  task automatic apply_reset();
    @(negedge clk);
    rstn           = 1'b0;
    bus4.req_valid = '0;
    bus4.m_ready   = 1'b0;
    bus3.req_valid = '0;
    bus3.m_ready   = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_data();
    for (int i = 0; i < 4; i++) bus4.req_data[i] = 16'h1000 + 16'(i);
    for (int i = 0; i < 3; i++) bus3.req_data[i] = 16'h3000 + 16'(i);
  endtask

  // Waits (bounded) for the next rising edge of m_valid on the 4-requester instance.
  task automatic wait_grant(output int id, output logic [15:0] data, output int cycles, output bit timeout);
    logic prev;
    prev    = bus4.m_valid;
    cycles  = 0;
    timeout = 1'b1;
    id      = -1;
    data    = 16'h0000;
    while (timeout && (cycles < 100)) begin
      @(negedge clk);
      cycles++;
      if (bus4.m_valid && !prev) begin
        id      = int'(bus4.grant_id);
        data    = bus4.m_data;
        timeout = 1'b0;
      end
      prev = bus4.m_valid;
    end
  endtask

  task automatic test_reset();
    rstn           = 1'b0;
    bus4.req_valid = 4'hF;
    bus4.req_data  = '0;
    bus4.m_ready   = 1'b1;
    bus3.req_valid = 3'h7;
    bus3.m_ready   = 1'b1;
    load_data();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus4.m_valid, bus4.busy, bus4.grant_id, bus4.m_data} !== 20'h0_0000) begin
      errors++;
      $display("FAIL reset_outputs: got mv=%0b busy=%0b id=%0d data=%h, want all 0",
               bus4.m_valid, bus4.busy, bus4.grant_id, bus4.m_data);
    end
    checks++;
    if (bus4.req_ready !== 4'b0000 || bus3.req_ready !== 3'b000) begin
      errors++;
      $display("FAIL reset_req_ready: got %b/%b, want 0000/000", bus4.req_ready, bus3.req_ready);
    end
    checks++;
    if ({bus3.m_valid, bus3.busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_dut3: got mv=%0b busy=%0b, want 0 0", bus3.m_valid, bus3.busy);
    end
    bus4.req_valid = '0;
    bus4.m_ready   = 1'b0;
    bus3.req_valid = '0;
    bus3.m_ready   = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    bus4.req_data    = '0;
    bus4.req_data[2] = 16'hA55A;
    bus4.req_valid   = 4'b0100;
    #1;
    checks++;
    if (bus4.req_ready !== 4'b0100 || bus4.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_accept: got req_ready=%b busy=%0b, want 0100 1", bus4.req_ready, bus4.busy);
    end
    @(negedge clk);
    bus4.req_valid = '0;
    #1;
    checks++;
    if (bus4.req_ready !== 4'b0000 || bus4.m_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: got req_ready=%b m_valid=%0b, want 0000 1", bus4.req_ready, bus4.m_valid);
    end
    checks++;
    if (bus4.m_data !== 16'hA55A || bus4.grant_id !== 2'd2) begin
      errors++;
      $display("FAIL single_data: got data=%h id=%0d, want a55a 2", bus4.m_data, bus4.grant_id);
    end
    bus4.m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus4.m_valid !== 1'b0 || bus4.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_handshake: got m_valid=%0b busy=%0b, want 0 1", bus4.m_valid, bus4.busy);
    end
  endtask

  task automatic test_rotation();
    int id, cyc;
    logic [15:0] data;
    bit to;
    apply_reset();
    load_data();
    bus4.req_valid = 4'hF;
    bus4.m_ready   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(id, data, cyc, to);
      checks++;
      if (to !== 1'b0 || id !== (k % 4) || data !== (16'h1000 + 16'(k % 4))) begin
        errors++;
        $display("FAIL rotation_grant%0d: got id=%0d data=%h timeout=%0b, want id=%0d data=%h",
                 k, id, data, to, k % 4, 16'h1000 + 16'(k % 4));
      end
      checks++;
      if (cyc !== ((k == 0) ? 1 : 34)) begin
        errors++;
        $display("FAIL rotation_spacing%0d: got %0d clocks, want %0d", k, cyc, (k == 0) ? 1 : 34);
      end
    end
  endtask

  task automatic test_stall();
    int id, cyc;
    logic [15:0] data;
    bit to;
    int bad;
    apply_reset();
    load_data();
    bus4.req_valid = 4'hF;
    bus4.m_ready   = 1'b0;
    wait_grant(id, data, cyc, to);
    checks++;
    if (to !== 1'b0 || id !== 0) begin
      errors++;
      $display("FAIL stall_grant: got id=%0d timeout=%0b, want id=0", id, to);
    end
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus4.m_valid !== 1'b1 || bus4.m_data !== 16'h1000 || bus4.grant_id !== 2'd0 || bus4.req_ready !== 4'b0000) begin
        bad++;
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL stall_hold: got %0d unstable cycles of 50, want 0", bad);
    end
    bus4.m_ready = 1'b1;
    @(negedge clk);
    bus4.m_ready = 1'b0;
    checks++;
    if (bus4.m_valid !== 1'b0 || bus4.busy !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got m_valid=%0b busy=%0b, want 0 1", bus4.m_valid, bus4.busy);
    end
  endtask

  task automatic test_reset_mid_send();
    int id, cyc;
    logic [15:0] data;
    bit to;
    apply_reset();
    load_data();
    bus4.req_valid = 4'hF;
    bus4.m_ready   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_grant(id, data, cyc, to);
      checks++;
      if (to !== 1'b0 || id !== k) begin
        errors++;
        $display("FAIL midrst_pre%0d: got id=%0d timeout=%0b, want id=%0d", k, id, to, k);
      end
      if (k < 2) begin
        bus4.m_ready = 1'b1;
        @(negedge clk);
        bus4.m_ready = 1'b0;
      end
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus4.m_valid, bus4.busy, bus4.req_ready, bus4.m_data} !== 22'h0) begin
      errors++;
      $display("FAIL midrst_clear: got mv=%0b busy=%0b rdy=%b data=%h, want all 0",
               bus4.m_valid, bus4.busy, bus4.req_ready, bus4.m_data);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    wait_grant(id, data, cyc, to);
    checks++;
    if (to !== 1'b0 || id !== 0 || data !== 16'h1000) begin
      errors++;
      $display("FAIL midrst_restart: got id=%0d data=%h timeout=%0b, want id=0 data=1000", id, data, to);
    end
  endtask

  task automatic test_gap0();
    logic [2:0] exp_rdy;
    logic       exp_mv;
    int         bad;
    apply_reset();
    load_data();
    bus3.req_valid = 3'b010;
    bus3.m_ready   = 1'b1;
    #1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      exp_rdy = ((k % 2) == 0) ? 3'b010 : 3'b000;
      exp_mv  = ((k % 2) == 1);
      if (bus3.req_ready !== exp_rdy || bus3.m_valid !== exp_mv || bus3.busy !== 1'b1) begin
        bad++;
        $display("FAIL gap0_step%0d: got rdy=%b mv=%0b busy=%0b, want rdy=%b mv=%0b busy=1",
                 k, bus3.req_ready, bus3.m_valid, bus3.busy, exp_rdy, exp_mv);
      end
      @(negedge clk);
      #1;
    end
    checks++;
    if (bad !== 0) errors++;
    apply_reset();
    bus3.req_valid = 3'b111;
    bus3.m_ready   = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (bus3.req_ready !== (3'b001 << (g % 3))) begin
        errors++;
        $display("FAIL wrap_ready%0d: got %b, want %b", g, bus3.req_ready, 3'b001 << (g % 3));
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus3.grant_id !== 2'(g % 3) || bus3.m_data !== (16'h3000 + 16'(g % 3))) begin
        errors++;
        $display("FAIL wrap_grant%0d: got id=%0d data=%h, want id=%0d data=%h",
                 g, bus3.grant_id, bus3.m_data, g % 3, 16'h3000 + 16'(g % 3));
      end
      @(negedge clk);
      #1;
    end
  endtask

`ifdef UART_ARB_PRIO_EN
  task automatic test_prio();
    int id, cyc;
    logic [15:0] data;
    bit to;
    int exp_ids[7] = '{0, 0, 0, 1, 2, 3, 1};
    apply_reset();
    load_data();
    bus4.req_valid = 4'hF;
    bus4.m_ready   = 1'b1;
    for (int k = 0; k < 7; k++) begin
      wait_grant(id, data, cyc, to);
      checks++;
      if (to !== 1'b0 || id !== exp_ids[k]) begin
        errors++;
        $display("FAIL prio_grant%0d: got id=%0d timeout=%0b, want id=%0d", k, id, to, exp_ids[k]);
      end
      if (k == 2) bus4.req_valid = 4'b1110;
    end
  endtask
`else
  task automatic test_drop();
    int id, cyc;
    logic [15:0] data;
    bit to;
    int exp_ids[3] = '{0, 2, 3};
    apply_reset();
    load_data();
    bus4.req_valid = 4'hF;
    bus4.m_ready   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_grant(id, data, cyc, to);
      checks++;
      if (to !== 1'b0 || id !== exp_ids[k]) begin
        errors++;
        $display("FAIL drop_grant%0d: got id=%0d timeout=%0b, want id=%0d", k, id, to, exp_ids[k]);
      end
      bus4.req_valid = (k == 0) ? 4'b1101 : 4'b1111;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rotation();
    test_stall();
    test_reset_mid_send();
    test_gap0();
`ifdef UART_ARB_PRIO_EN
    test_prio();
`else
    test_drop();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by time limit, want finish");
    $fatal(1, "time limit");
  end
endmodule
